mem_access_unit: RTL

//  Downstream consumer of the ALU: takes the ALU result as a byte address
//  for lw/sw and runs one word access on a ready-handshaked data memory.

---
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs one lw/sw word access on a ready-handshaked data memory.
// It uses the ALU result as the byte address and blocks the access on
// misalignment, ALU overflow or memory timeout.
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   start                1-cycle pulse; only sampled in IDLE
//   is_load, is_store    access type (load wins if both are set)
//   alu_result, alu_ovf  byte address and overflow flag from the ALU
//   store_data           write data for sw
//   mem_req/we/addr/wdata/rdata/ready  memory handshake
//   stall                combinational: pipeline freeze while busy
//   done                 1-cycle completion pulse (ok or error)
//   load_data            last successfully loaded word
//   err_align/ovf/tmo    sticky error flags
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err_align,
    output logic        err_ovf,
    output logic        err_tmo
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam int unsigned LAST_CNT = TIMEOUT - 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept_c;
    logic             bad_align_c;
    logic             launch_c;
    logic             capture_c;
    logic             tmo_c;

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture_c   = 1'b0;
        tmo_c       = 1'b0;
        accept_c    = (state == S_IDLE) & start & (is_load | is_store);
        bad_align_c = (alu_result[1:0] != 2'b00);
        launch_c    = accept_c & ~bad_align_c & ~alu_ovf;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nxt = launch_c ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                cnt_nxt = '0;
                if (mem_ready) begin
                    state_nxt = S_DONE;
                    capture_c = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // mem_ready takes precedence over an expiring timeout
                if (mem_ready) begin
                    state_nxt = S_DONE;
                    capture_c = 1'b1;
                end else if (cnt == CNT_W'(LAST_CNT)) begin
                    state_nxt = S_DONE;
                    tmo_c     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall must freeze the pipeline in the same cycle the access is accepted
    assign stall = (state != S_IDLE) | accept_c;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            load_data <= '0;
            err_align <= 1'b0;
            err_ovf   <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mem_req <= (state_nxt == S_REQ) | (state_nxt == S_WAIT);
            done    <= (state_nxt == S_DONE);
            if (launch_c) begin
                mem_addr  <= alu_result[31:2];
                mem_wdata <= store_data;
                mem_we    <= is_store & ~is_load;
            end
            if (capture_c && !mem_we) begin
                load_data <= mem_rdata;
            end
            if (accept_c && bad_align_c) begin
                err_align <= 1'b1;
            end
            if (accept_c && !bad_align_c && alu_ovf) begin
                err_ovf <= 1'b1;
            end
            if (tmo_c) begin
                err_tmo <= 1'b1;
            end
        end
    end

endmodule
